// File: rtl/io_out_arbiter_if.sv
// io_out_arbiter_if: requester-side and sink-side signals of the character output arbiter.
//   up_req/up_data/up_ack : per-requester 4-phase handshake, requester i data at [i*WIDTH +: WIDTH]
//   dn_req/dn_data/dn_ack : 4-phase handshake to the shared output device
//   grant_id/busy         : current (or most recent) winner and transfer-in-progress status
// Modports: slave is the arbiter's view, master is the requesters plus device (environment).
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

interface io_out_arbiter_if #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = `WORD_SIZE,
  parameter int unsigned IDXW  = 3
);
  logic [NREQ-1:0]       up_req;
  logic [NREQ*WIDTH-1:0] up_data;
  logic [NREQ-1:0]       up_ack;
  logic                  dn_req;
  logic                  dn_ack;
  logic [WIDTH-1:0]      dn_data;
  logic [IDXW-1:0]       grant_id;
  logic                  busy;

  modport slave (
    input  up_req, up_data, dn_ack,
    output up_ack, dn_req, dn_data, grant_id, busy
  );

  modport master (
    output up_req, up_data, dn_ack,
    input  up_ack, dn_req, dn_data, grant_id, busy
  );
endinterface

// File: rtl/io_out_arbiter.sv
// io_out_arbiter: shares one 4-phase character output device between NREQ requesters.
// Round-robin winner selection, the winner's data is latched on the grant edge, the
// downstream handshake completes fully before the upstream acknowledge is raised.
// Ports:
//   clk      : system clock, all state on the rising edge
//   areset_n : asynchronous active-low reset
//   bus      : io_out_arbiter_if.slave (up_req, up_data, up_ack, dn_req, dn_ack,
//              dn_data, grant_id, busy); every output is a flop.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module io_out_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = `WORD_SIZE,
  parameter int unsigned IDXW  = 3
) (
  input logic             clk,
  input logic             areset_n,
  io_out_arbiter_if.slave bus
);

  // Width of an index that addresses exactly the NREQ requester slots.
  localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    DN_REQ = 2'd1,
    DN_REL = 2'd2,
    UP_ACK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              dn_req_q, dn_req_d;
  logic [NREQ-1:0]   up_ack_q, up_ack_d;
  logic [WIDTH-1:0]  dn_data_q, dn_data_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic              busy_q, busy_d;

  logic [IDXW-1:0]   winner_c;
  logic [RW-1:0]     win_ix_c;
  logic              any_req_c;
  logic [WIDTH-1:0]  data_arr [NREQ];

  // Unpack the flat data bus into one word per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign data_arr[gi] = bus.up_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: first pending requester after the last winner, wrapping.
  always_comb begin : rr_pick
    int unsigned idx;
    idx       = 0;
    winner_c  = '0;
    win_ix_c  = '0;
    any_req_c = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_q) + k) % NREQ;
      if (!any_req_c && bus.up_req[RW'(idx)]) begin
        any_req_c = 1'b1;
        winner_c  = IDXW'(idx);
        win_ix_c  = RW'(idx);
      end
    end
  end

  // Next-state and next-output logic; everything holds unless a transition fires.
  always_comb begin : fsm_next
    state_d   = state_q;
    dn_req_d  = dn_req_q;
    up_ack_d  = up_ack_q;
    dn_data_d = dn_data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    busy_d    = busy_q;
    case (state_q)
      ARB: begin
        if (any_req_c) begin
          dn_data_d = data_arr[win_ix_c];
          grant_d   = winner_c;
          dn_req_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = DN_REQ;
        end
      end
      DN_REQ: begin
        if (bus.dn_ack) begin
          dn_req_d = 1'b0;
          state_d  = DN_REL;
        end
      end
      DN_REL: begin
        if (!bus.dn_ack) begin
          up_ack_d = NREQ'(1) << grant_q;
          state_d  = UP_ACK;
        end
      end
      UP_ACK: begin
        // Leaving only after a sampled low keeps up_ack up for at least one cycle,
        // even if the requester already withdrew its request.
        if (!bus.up_req[RW'(grant_q)]) begin
          up_ack_d = '0;
          busy_d   = 1'b0;
          last_d   = grant_q;
          state_d  = ARB;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge areset_n) begin : regs
    if (!areset_n) begin
      state_q   <= ARB;
      dn_req_q  <= 1'b0;
      up_ack_q  <= '0;
      dn_data_q <= '0;
      grant_q   <= '0;
      last_q    <= IDXW'(NREQ - 1);
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dn_req_q  <= dn_req_d;
      up_ack_q  <= up_ack_d;
      dn_data_q <= dn_data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.dn_req   = dn_req_q;
  assign bus.up_ack   = up_ack_q;
  assign bus.dn_data  = dn_data_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/io_out_arbiter.md
Name: io_out_arbiter

Overview:
- Shares one character output device (4-phase req/ack sink, 8-bit payload in the low bits of a word) between NREQ requesters, e.g. CPU store path and debug/trace unit.
- Round-robin arbitration. Latches the winner's data and runs a full 4-phase handshake downstream before completing the 4-phase handshake upstream.
- Sits between the requesters and the output device; one transfer in flight at a time.

Parameters:
NREQ, 2, number of requesters (2..8)
WIDTH, `WORD_SIZE, data word width
IDXW, 3, width of grant index (must satisfy 2**IDXW >= NREQ)

Ports:
clk  in  1  system clock, all state on rising edge
areset_n  in  1  asynchronous active-low reset
up_req  in  NREQ  per-requester request (4-phase)
up_data  in  NREQ*WIDTH  per-requester data, requester i at bits [i*WIDTH +: WIDTH]
up_ack  out  NREQ  per-requester acknowledge (one-hot or zero)
dn_req  out  1  request to output device
dn_ack  in  1  acknowledge from output device
dn_data  out  WIDTH  latched data to output device
grant_id  out  IDXW  index of current or most recent winner
busy  out  1  high in any state other than ARB

Behaviour:
- Reset (async assert, sync-free): state=ARB, dn_req=0, up_ack=0, dn_data=0, grant_id=0, busy=0, rr pointer last=NREQ-1, so requester 0 has first priority.
- All outputs are registered; no combinational path from any input to any output.
- States: ARB, DN_REQ, DN_REL, UP_ACK.
- ARB: if any up_req bit is set, select the first set bit searching last+1, last+2, ... (mod NREQ). On that edge: latch up_data[winner] into dn_data, grant_id=winner, dn_req=1, busy=1, go to DN_REQ. With no requests, stay in ARB and hold outputs.
- DN_REQ: hold dn_req=1. When dn_ack=1 is sampled: dn_req=0, go to DN_REL.
- DN_REL: when dn_ack=0 is sampled: up_ack[grant_id]=1, go to UP_ACK.
- UP_ACK: when up_req[grant_id]=0 is sampled: up_ack=0, busy=0, last=grant_id, go to ARB.
- up_ack is high for at least 1 cycle even if the requester has already dropped req.
- Latency: up_req sampled at edge k gives dn_req high after edge k. With the standard sink (ack 2 cycles after req), one transfer takes ARB→UP_ACK→ARB in 6 cycles when the requester drops req immediately.
- dn_data is stable from the grant edge until the next grant. Later changes on up_data or up_req of any requester do not affect an in-flight transfer.
- Requests from non-granted requesters are held pending and considered only in ARB.
- The same requester may win back-to-back only if no other requester is pending.
- A requester that drops up_req before up_ack (protocol violation) does not abort the transfer. The downstream transfer completes, up_ack pulses for 1 cycle, then the block returns to ARB.
- dn_ack high while in ARB or UP_ACK is ignored.
- Reset mid-transfer: all outputs clear immediately. Downstream may be left in its ack state; it recovers when dn_req is seen low.
- NREQ=1 degenerates to a pass-through sequencer with the same timing.

Test Plan:
- Single request: up_req[0]=1, data=0x41, sink acks 2 cycles after dn_req → dn_data=0x41 latched on the grant edge, dn_req high 3 cycles, up_ack[0] high after dn_ack falls, busy falls 1 cycle after up_req[0] drops.
- Simultaneous: up_req=2'b11 held, data0=0x30, data1=0x31, 4 transfers → order 0,1,0,1; grant_id alternates; dn_data sequence 0x30,0x31,0x30,0x31.
- Data stability: after the grant of 0x55, the requester changes up_data to 0xAA → the device receives 0x55; 0xAA is sent only on the next request.
- Slow sink: dn_ack delayed 10 cycles high and 5 cycles low → dn_req holds, up_ack stays 0 until dn_ack falls; no second grant occurs.
- Early drop: up_req[1] drops in DN_REQ → transfer completes, up_ack[1] is a 1-cycle pulse, block returns to ARB, no extra dn_req.
- Reset mid-transfer: assert areset_n=0 in DN_REQ, asynchronously between clock edges → dn_req, up_ack, busy are 0 before the next edge. After release with up_req=2'b11, requester 0 wins first.
